// File: rtl/uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// uart_rx_ovs
// 16x oversampling UART receiver with a one-entry output buffer.
//
// A free-running divisor produces one oversample tick per 1/16 bit time. The
// serial input is synchronized, a start bit is qualified at its midpoint, and
// data / parity / stop bits are sampled at the midpoint of each bit. The
// finished byte lands in a single holding buffer with a valid/ready handshake.
//
// Parameters
//   SYNC_STAGES  number of flops in the rx synchronizer (2..3)
//   DIV_SHIFT    right shift applied to every nominal divisor; 0 gives the
//                nominal 2400/4800/9600/19200 rates at 50 MHz
//
// Ports
//   clock       system clock (50 MHz)
//   reset_n     asynchronous active-low reset
//   baud_rate   00=2400, 01=4800, 10=9600, 11=19200
//   parity_en   frame carries a parity bit after the data bits
//   parity_odd  1 = odd parity, 0 = even parity
//   rx          serial line, idle high, asynchronous to clock
//   rx_data     received byte, LSB first on the line
//   rx_valid    rx_data and error flags are valid
//   rx_ready    consumer accepts the byte when rx_valid & rx_ready
//   parity_err  parity mismatch for the held byte
//   frame_err   stop bit sampled low for the held byte
//   overrun     sticky: a frame was dropped because the buffer was full
//   busy        receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_ovs #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_SHIFT   = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] baud_rate,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Terminal counts of the divisor (period minus one) for each rate.
    localparam logic [13:0] LAST_2400  = 14'((1302 >> DIV_SHIFT) - 1);
    localparam logic [13:0] LAST_4800  = 14'((651 >> DIV_SHIFT) - 1);
    localparam logic [13:0] LAST_9600  = 14'((326 >> DIV_SHIFT) - 1);
    localparam logic [13:0] LAST_19200 = 14'((163 >> DIV_SHIFT) - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    logic [13:0] div_q, div_d;
    logic [13:0] div_last;
    logic        tick;

    state_t      state_q, state_d;
    logic [3:0]  samp_q, samp_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        armed_q, armed_d;
    logic        perr_pend_q, perr_pend_d;
    logic        ferr_pend_q, ferr_pend_d;
    logic        deliver_q, deliver_d;

    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic        handshake;
    logic        buf_free;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    assign rx_s   = sync_q[SYNC_STAGES-1];

    always_comb begin
        case (baud_rate)
            2'b00:   div_last = LAST_2400;
            2'b01:   div_last = LAST_4800;
            2'b10:   div_last = LAST_9600;
            default: div_last = LAST_19200;
        endcase
    end

    // Greater-or-equal compare: if the rate is raised mid-count the counter
    // wraps on the next clock instead of running all the way around.
    assign tick = (div_q >= div_last);

    // Receiver FSM: next state, sample/bit counters and pending frame flags.
    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        deliver_d   = 1'b0;
        div_d       = tick ? 14'd0 : div_q + 14'd1;

        if (tick && (state_q != ST_IDLE)) begin
            samp_d = samp_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                // A line held low after a framing error must go high again
                // before another start bit is accepted.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d     = ST_START;
                    samp_d      = 4'd0;
                    div_d       = 14'd0;
                    bit_d       = 3'd0;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick && (samp_q == 4'd7)) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        samp_d  = 4'd0;
                    end
                end
            end
            ST_DATA: begin
                if (tick && (samp_q == 4'd15)) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = parity_en ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick && (samp_q == 4'd15)) begin
                    perr_pend_d = (^shift_q) ^ rx_s ^ parity_odd;
                    state_d     = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick && (samp_q == 4'd15)) begin
                    ferr_pend_d = ~rx_s;
                    deliver_d   = 1'b1;
                    state_d     = ST_IDLE;
                    if (!rx_s) begin
                        armed_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output buffer: a delivery finding the buffer occupied (and not being
    // emptied this cycle) is dropped and recorded in the sticky overrun flag.
    assign handshake = valid_q & rx_ready;
    assign buf_free  = ~valid_q | handshake;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        if (deliver_q) begin
            if (buf_free) begin
                valid_d = 1'b1;
                data_d  = shift_q;
                perr_d  = perr_pend_q;
                ferr_d  = ferr_pend_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '1;
            div_q       <= 14'd0;
            state_q     <= ST_IDLE;
            samp_q      <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            armed_q     <= 1'b1;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            deliver_q   <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            div_q       <= div_d;
            state_q     <= state_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            deliver_q   <= deliver_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ovs
// Bench for uart_rx_ovs. One instance runs with shortened bit times and is
// driven with directed and random frames; a second instance at nominal rates
// is used to measure the real oversample divisor for every rate select.
// ---------------------------------------------------------------------------
module tb_uart_rx_ovs;

    localparam int SHIFT = 5;

    logic       clock;
    logic       reset_n;
    logic [1:0] baud_rate;
    logic       parity_en;
    logic       parity_odd;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic       full_reset_n;
    logic [1:0] full_baud;
    logic       full_rx;
    logic [7:0] full_data;
    logic       full_valid;
    logic       full_perr;
    logic       full_ferr;
    logic       full_ovr;
    logic       full_busy;

    // Reference model of the output buffer
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovr;
    logic       in_window;
    logic       check_en;

    int nChecks;
    int nFails;

    uart_rx_ovs #(.SYNC_STAGES(2), .DIV_SHIFT(SHIFT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .baud_rate  (baud_rate),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    uart_rx_ovs full_dut (
        .clock      (clock),
        .reset_n    (full_reset_n),
        .baud_rate  (full_baud),
        .parity_en  (1'b0),
        .parity_odd (1'b0),
        .rx         (full_rx),
        .rx_data    (full_data),
        .rx_valid   (full_valid),
        .rx_ready   (1'b0),
        .parity_err (full_perr),
        .frame_err  (full_ferr),
        .overrun    (full_ovr),
        .busy       (full_busy)
    );

    // 50 MHz clock
    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    function automatic int nominalDiv(input logic [1:0] sel);
        case (sel)
            2'b00:   return 1302;
            2'b01:   return 651;
            2'b10:   return 326;
            default: return 163;
        endcase
    endfunction

    function automatic int bitTime(input logic [1:0] sel);
        return 16 * (nominalDiv(sel) >> SHIFT);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison of the buffer outputs against the model,
    // skipped only while a delivery is in flight.
    always @(negedge clock) begin
        if (check_en && !in_window) begin
            checkOutput("cycValid", 32'(rx_valid), 32'(m_valid));
            if (m_valid) begin
                checkOutput("cycData", 32'(rx_data), 32'(m_data));
                checkOutput("cycParityErr", 32'(parity_err), 32'(m_perr));
                checkOutput("cycFrameErr", 32'(frame_err), 32'(m_ferr));
            end
            checkOutput("cycOverrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic modelDeliver(input logic [7:0] d, input logic pe, input logic fe,
                                input bit hs);
        if (!m_valid || hs) begin
            m_valid = 1'b1;
            m_data  = d;
            m_perr  = pe;
            m_ferr  = fe;
            if (hs) m_ovr = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic handshake();
        @(negedge clock);
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    // Send one frame at the current settings; optionally pulse rx_ready so
    // that it coincides with the delivery of this frame.
    task automatic applyStimulus(input logic [7:0] d, input logic pbit, input logic stopb,
                                 input bit hsAtDeliver);
        int   t;
        int   used;
        int   ones;
        bit   seen;
        logic pe;
        t = bitTime(baud_rate);
        @(negedge clock);
        rx = 1'b0;
        repeat (t) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (t) @(negedge clock);
        end
        if (parity_en) begin
            rx = pbit;
            repeat (t) @(negedge clock);
        end
        rx        = stopb;
        in_window = 1'b1;
        used      = 0;
        seen      = 1'b0;
        if (hsAtDeliver) begin
            while (used < t && !seen) begin
                @(negedge clock);
                used++;
                if (!busy) seen = 1'b1;
            end
            checkOutput("hsWaitBusyLow", 32'(seen), 32'd1);
            if (seen) begin
                rx_ready = 1'b1;
                @(negedge clock);
                used++;
                rx_ready = 1'b0;
            end
        end
        if (t > used) repeat (t - used) @(negedge clock);
        rx   = 1'b1;
        ones = $countones(d) + int'(pbit) + int'(parity_odd);
        pe   = parity_en & ((ones % 2) == 1);
        modelDeliver(d, pe, ~stopb, hsAtDeliver && seen);
        in_window = 1'b0;
        checkOutput("idleAfterFrame", 32'(busy), 32'd0);
    endtask

    // Nominal-rate instance: a short low pulse enters START, which lasts
    // exactly eight oversample ticks before the false start is rejected.
    task automatic measureDivisors();
        int cnt;
        int guard;
        repeat (3) @(negedge clock);
        full_reset_n = 1'b1;
        repeat (5) @(negedge clock);
        for (int s = 0; s < 4; s++) begin
            full_baud = 2'(s);
            repeat (4) @(negedge clock);
            full_rx = 1'b0;
            repeat (3) @(negedge clock);
            full_rx = 1'b1;
            cnt   = 0;
            guard = 0;
            while (guard < 30000) begin
                if (full_busy) cnt++;
                else if (cnt > 0) break;
                @(negedge clock);
                guard++;
            end
            checkOutput("divPeriod", 32'(cnt), 32'(8 * nominalDiv(2'(s))));
            checkOutput("divNoFrame", 32'(full_valid), 32'd0);
        end
    endtask

    task automatic mainSequence();
        int         t;
        logic [7:0] d;

        // Basic byte at 19200, no parity, consumer stalled
        baud_rate = 2'b11;
        t = bitTime(baud_rate);
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0);
        idle(3 * t);
        checkOutput("basicValid", 32'(rx_valid), 32'd1);
        checkOutput("basicData", 32'(rx_data), 32'hA5);
        checkOutput("basicPerr", 32'(parity_err), 32'd0);
        checkOutput("basicFerr", 32'(frame_err), 32'd0);
        checkOutput("basicOvr", 32'(overrun), 32'd0);
        handshake();
        checkOutput("basicAfterHs", 32'(rx_valid), 32'd0);

        // Even parity at 9600
        baud_rate  = 2'b10;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        idle(10);
        applyStimulus(8'h03, 1'b0, 1'b1, 1'b0);
        checkOutput("parOkErr", 32'(parity_err), 32'd0);
        checkOutput("parOkData", 32'(rx_data), 32'h03);
        handshake();
        applyStimulus(8'h03, 1'b1, 1'b1, 1'b0);
        checkOutput("parBadErr", 32'(parity_err), 32'd1);
        checkOutput("parBadData", 32'(rx_data), 32'h03);
        handshake();

        // Glitch of four oversample ticks at 19200
        baud_rate = 2'b11;
        parity_en = 1'b0;
        t = bitTime(baud_rate);
        idle(10);
        rx = 1'b0;
        idle(4 * (nominalDiv(baud_rate) >> SHIFT));
        rx = 1'b1;
        idle(16 * (nominalDiv(baud_rate) >> SHIFT) + 10);
        checkOutput("glitchBusy", 32'(busy), 32'd0);
        checkOutput("glitchValid", 32'(rx_valid), 32'd0);
        idle(t);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0);
        checkOutput("glitchNextData", 32'(rx_data), 32'h5A);
        handshake();

        // Break: three frame times low
        idle(t);
        @(negedge clock);
        rx = 1'b0;
        idle(9 * t);
        in_window = 1'b1;
        idle(t);
        modelDeliver(8'h00, 1'b0, 1'b1, 1'b0);
        in_window = 1'b0;
        idle(20 * t);
        checkOutput("breakNoRestart", 32'(busy), 32'd0);
        rx = 1'b1;
        idle(4 * t);
        checkOutput("breakValid", 32'(rx_valid), 32'd1);
        checkOutput("breakData", 32'(rx_data), 32'h00);
        checkOutput("breakFerr", 32'(frame_err), 32'd1);
        handshake();
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0);
        checkOutput("afterBreakData", 32'(rx_data), 32'h3C);
        handshake();

        // Overrun with the consumer stalled, then cleared by a handshake
        applyStimulus(8'h11, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b1, 1'b0);
        checkOutput("ovrData", 32'(rx_data), 32'h11);
        checkOutput("ovrFlag", 32'(overrun), 32'd1);
        handshake();
        checkOutput("ovrHsValid", 32'(rx_valid), 32'd0);
        checkOutput("ovrHsFlag", 32'(overrun), 32'd0);

        // Handshake on the same clock as the delivery of 0x22
        applyStimulus(8'h11, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h77, 1'b0, 1'b1, 1'b0);
        checkOutput("ovrPreFlag", 32'(overrun), 32'd1);
        applyStimulus(8'h22, 1'b0, 1'b1, 1'b1);
        checkOutput("sameClkData", 32'(rx_data), 32'h22);
        checkOutput("sameClkValid", 32'(rx_valid), 32'd1);
        checkOutput("sameClkOvr", 32'(overrun), 32'd0);
        applyStimulus(8'h44, 1'b0, 1'b1, 1'b0);

        // Reset during data bit 4 at 2400
        baud_rate = 2'b00;
        t = bitTime(baud_rate);
        idle(10);
        d = 8'h96;
        @(negedge clock);
        rx = 1'b0;
        idle(t);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            idle(t);
        end
        rx = d[4];
        idle(t / 2);
        checkOutput("midFrameBusy", 32'(busy), 32'd1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        rx      = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        #1;
        checkOutput("rstValid", 32'(rx_valid), 32'd0);
        checkOutput("rstData", 32'(rx_data), 32'h00);
        checkOutput("rstPerr", 32'(parity_err), 32'd0);
        checkOutput("rstFerr", 32'(frame_err), 32'd0);
        checkOutput("rstOvr", 32'(overrun), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        idle(10);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        idle(2 * t);
        checkOutput("postRstBusy", 32'(busy), 32'd0);
        applyStimulus(8'hC3, 1'b0, 1'b1, 1'b0);
        checkOutput("postRstData", 32'(rx_data), 32'hC3);
        checkOutput("postRstValid", 32'(rx_valid), 32'd1);
        checkOutput("postRstPerr", 32'(parity_err), 32'd0);
        checkOutput("postRstFerr", 32'(frame_err), 32'd0);
        checkOutput("postRstOvr", 32'(overrun), 32'd0);
        handshake();

        // Random frames, settings changed only between frames
        for (int n = 0; n < 10; n++) begin
            baud_rate  = 2'($urandom_range(1, 3));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            t = bitTime(baud_rate);
            if ($urandom_range(0, 1) == 1) handshake();
            idle($urandom_range(2, t));
            applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0), 1'b0);
        end
        idle(20);
        handshake();
        idle(20);
    endtask

    initial begin
        nChecks      = 0;
        nFails       = 0;
        reset_n      = 1'b0;
        rx           = 1'b1;
        rx_ready     = 1'b0;
        baud_rate    = 2'b11;
        parity_en    = 1'b0;
        parity_odd   = 1'b0;
        full_reset_n = 1'b0;
        full_baud    = 2'b00;
        full_rx      = 1'b1;
        m_valid      = 1'b0;
        m_data       = 8'h00;
        m_perr       = 1'b0;
        m_ferr       = 1'b0;
        m_ovr        = 1'b0;
        in_window    = 1'b0;
        check_en     = 1'b0;

        repeat (3) @(negedge clock);
        checkOutput("resetValid", 32'(rx_valid), 32'd0);
        checkOutput("resetData", 32'(rx_data), 32'h00);
        checkOutput("resetPerr", 32'(parity_err), 32'd0);
        checkOutput("resetFerr", 32'(frame_err), 32'd0);
        checkOutput("resetOvr", 32'(overrun), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        reset_n  = 1'b1;
        check_en = 1'b1;
        idle(20);
        $display("[TB] starting directed and random frames");

        fork
            measureDivisors();
            mainSequence();
        join

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops in the rx input synchronizer (legal 2..3).
REQ-002 clock  input  1  system clock, 50 MHz.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 baud_rate  input  2  rate select: 00=2400, 01=4800, 10=9600, 11=19200.
REQ-005 parity_en  input  1  1 = frame carries one parity bit after the data bits.
REQ-006 parity_odd  input  1  1 = odd parity, 0 = even parity; ignored when parity_en=0.
REQ-007 rx  input  1  serial line, asynchronous to clock, idle high.
REQ-008 rx_data  output  8  received byte, LSB received first.
REQ-009 rx_valid  output  1  rx_data and error flags are valid.
REQ-010 rx_ready  input  1  consumer accepts the byte when rx_valid=1 and rx_ready=1.
REQ-011 parity_err  output  1  parity mismatch for the byte currently held.
REQ-012 frame_err  output  1  stop bit sampled low for the byte currently held.
REQ-013 overrun  output  1  sticky flag: at least one frame was lost.
REQ-014 busy  output  1  high in every FSM state other than IDLE.

Function
REQ-015 Oversample tick:
- Free-running divisor counter generates a 1-clock tick at 16x the baud rate.
- Period N clocks, with N = 1302 / 651 / 326 / 163 for selects 00 / 01 / 10 / 11.
- Counter counts 0..N-1; the tick fires on the cycle the count equals N-1, and the count then wraps to 0.
REQ-016 Divisor compare uses >= N-1, so that lowering N mid-count wraps on the next clock and never runs to 2^14.
REQ-017 rx passes through SYNC_STAGES flops, each reset to 1; the FSM uses only the synchronized value rx_s.
REQ-018 FSM states are IDLE, START, DATA, PARITY and STOP; a 4-bit sample counter advances on each tick.
REQ-019 IDLE to START:
- Transition occurs when rx_s=0 and the armed flag is 1.
- On entry, clear the sample counter and resynchronize the divisor counter to 0.
REQ-020 START:
- At sample count 7, if rx_s=0, go to DATA and clear the sample counter.
- If rx_s=1, treat it as a false start, return to IDLE and set no flags.
REQ-021 DATA:
- Sample rx_s at sample count 15 into a shift register, LSB first.
- After the 8th bit, go to PARITY if parity_en=1, otherwise go to STOP.
REQ-022 PARITY: at sample count 15, compute error = (XOR of 8 data bits XOR rx_s XOR parity_odd) != 0, then go to STOP.
REQ-023 STOP:
- Sample rx_s at sample count 15.
- frame_err_next = ~rx_s.
- Go to IDLE.
- If rx_s=0, clear armed; armed sets again when rx_s=1 is seen in IDLE (break handling).
REQ-024 One clock after the stop-bit sample, the byte is delivered:
- If the buffer is free, load rx_data, parity_err and frame_err and set rx_valid.
- The buffer is free if rx_valid=0, or a handshake occurs in that same cycle.
- If the buffer is not free, discard the new frame, keep the old contents and set overrun.
REQ-025 rx_valid, rx_data, parity_err and frame_err hold stable until the handshake; after a handshake with no new frame, rx_valid=0 on the next clock.
REQ-026 overrun clears on the clock after a handshake, unless a discard occurs in the same cycle; the discard wins.
REQ-027 Frames with frame_err or parity_err are still delivered, with the flag set.
REQ-028 parity_en, parity_odd and baud_rate are sampled continuously; changing them while busy=1 gives an undefined frame but SHALL NOT hang the FSM, which returns to IDLE within one frame time.

Reset
REQ-029 On reset_n=0, the following take these values immediately and asynchronously:
- FSM = IDLE; divisor and sample counters = 0.
- Synchronizer flops = 1; armed = 1.
- rx_data = 0x00; rx_valid, parity_err, frame_err, overrun and busy = 0.
REQ-030 Reset asserted mid-frame discards the partial frame; after release, the block waits for a fresh falling edge.

Verification
REQ-031 Basic byte, 19200 (bit time 2608 clocks), no parity:
- Stimulus: send 0xA5 with rx_ready=0.
- Required: rx_valid=1 with rx_data=0xA5, all flags 0, held until rx_ready=1; rx_valid=0 one clock after the handshake.
REQ-032 Parity, 9600, parity_en=1, parity_odd=0:
- Send 0x03 with parity bit 0: parity_err=0.
- Send 0x03 with parity bit 1: parity_err=1, rx_data=0x03.
REQ-033 Glitch rejection:
- Stimulus: rx low for 4 oversample ticks, then high.
- Required: busy returns to 0 with no rx_valid; a following valid 0x5A frame is received correctly.
REQ-034 Break:
- Stimulus: rx held low for 3 frame times, then released.
- Required: exactly one delivery, rx_data=0x00 with frame_err=1; no second frame until rx returns high.
REQ-035 Overrun:
- Stimulus: send 0x11 then 0x22, rx_ready=0 throughout.
- Required: rx_data stays 0x11 and overrun=1.
- Then assert rx_ready for 1 clock: rx_valid=0 and overrun=0.
- Separately, a handshake on the same clock as the 0x22 delivery gives rx_data=0x22, rx_valid=1, overrun=0.
REQ-036 Reset mid-frame, 2400:
- Stimulus: assert reset_n=0 during data bit 4 of a frame.
- Required: all outputs 0 immediately; after release, a full 0xC3 frame is received with no flags.
